// File: rtl/ysyx_23060025_arbiter_if.sv
// ysyx_23060025_arbiter_if
//   One request/response channel between a bus master and a memory-like
//   slave. The arbiter uses three of these: two slave-side (IFU, LSU) and
//   one master-side (shared memory port).
// Parameters:
//   ADDR_W  request address width
//   DATA_W  write/read data width (write mask is DATA_W/8 bits)
// Signals:
//   req_valid / req_ready                          request handshake
//   req_addr / req_wen / req_wdata / req_wmask     request payload
//   resp_valid / resp_rdata                        response (no ready; always accepted)
// Modports:
//   master  drives the request, receives the response
//   slave   receives the request, drives the response
interface ysyx_23060025_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic                  req_wen;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wmask;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/ysyx_23060025_arbiter.sv
// ysyx_23060025_arbiter
//   Two-master to one-memory-port arbiter with a single outstanding
//   transaction. m0 is the IFU, m1 is the LSU.
// Parameters:
//   ADDR_W, DATA_W  payload widths (must match the connected interfaces)
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   m0     IFU channel   (slave side)
//   m1     LSU channel   (slave side)
//   mem    shared memory (master side)
// Configuration:
//   YSYX_23060025_ARB_RR_EN  defined   -> round-robin between m0 and m1
//                            undefined -> fixed priority, m1 over m0
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no transaction; grant is chosen from the current requests
// ST_REQ  | request of the granted master presented on mem, awaiting ready
// ST_RESP | request accepted, waiting for mem_resp_valid
module ysyx_23060025_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ysyx_23060025_arbiter_if.slave  m0,
  ysyx_23060025_arbiter_if.slave  m1,
  ysyx_23060025_arbiter_if.master mem
);
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_grant;
  logic              w_grant_nxt;
  logic [1:0]        w_valid;
  logic              w_pick;
  logic [ADDR_W-1:0] w_addr;
  logic              w_wen;
  logic [DATA_W-1:0] w_wdata;
  logic [MASK_W-1:0] w_wmask;

  assign w_valid = {m1.req_valid, m0.req_valid};

`ifdef YSYX_23060025_ARB_RR_EN
  logic r_last;

  // With both requesting, the master not served last wins; a lone
  // requester always wins.
  assign w_pick = (&w_valid) ? ~r_last : w_valid[1];

  // Pointer follows every grant, so a lone requester also counts as served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (r_state == ST_IDLE && |w_valid) begin
      r_last <= w_pick;
    end
  end
`else
  assign w_pick = w_valid[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  assign w_addr  = r_grant ? m1.req_addr  : m0.req_addr;
  assign w_wen   = r_grant ? m1.req_wen   : m0.req_wen;
  assign w_wdata = r_grant ? m1.req_wdata : m0.req_wdata;
  assign w_wmask = r_grant ? m1.req_wmask : m0.req_wmask;

  // Read data is broadcast; only resp_valid qualifies it.
  assign m0.resp_rdata = mem.resp_rdata;
  assign m1.resp_rdata = mem.resp_rdata;

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    mem.req_valid   = 1'b0;
    mem.req_addr    = '0;
    mem.req_wen     = 1'b0;
    mem.req_wdata   = '0;
    mem.req_wmask   = '0;
    m0.req_ready    = 1'b0;
    m1.req_ready    = 1'b0;
    m0.resp_valid   = 1'b0;
    m1.resp_valid   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (|w_valid) begin
          w_state_nxt = ST_REQ;
          w_grant_nxt = w_pick;
        end
      end
      ST_REQ: begin
        // Grant is frozen here even if the granted master drops valid.
        mem.req_valid = 1'b1;
        mem.req_addr  = w_addr;
        mem.req_wen   = w_wen;
        mem.req_wdata = w_wdata;
        mem.req_wmask = w_wmask;
        m0.req_ready  = ~r_grant & mem.req_ready;
        m1.req_ready  =  r_grant & mem.req_ready;
        if (mem.req_ready) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        m0.resp_valid = ~r_grant & mem.resp_valid;
        m1.resp_valid =  r_grant & mem.resp_valid;
        if (mem.resp_valid) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_ysyx_23060025_arbiter.sv
module tb_ysyx_23060025_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_23060025_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  ysyx_23060025_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
  ysyx_23060025_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  ysyx_23060025_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0_if),
    .m1    (m1_if),
    .mem   (mem_if)
  );

  int checks = 0;
  int failures = 0;

  // Payload each master is currently presenting.
  logic [ADDR_W-1:0] p_addr  [2];
  logic              p_wen   [2];
  logic [DATA_W-1:0] p_wdata [2];
  logic [MASK_W-1:0] p_wmask [2];

  // Reference model: history of served masters since the last reset.
  int served_q[$];

  // Observations recorded by serve_mem for the scenario tasks to judge.
  int                o_gnt, o_rdy_cyc, o_req_cycles, o_early_resp, o_resp_reqv;
  int                o_rdy [2];
  int                o_resp [2];
  logic              o_first_valid, o_idle_valid, o_stable, o_timeout;
  logic [ADDR_W-1:0] o_addr;
  logic              o_wen;
  logic [DATA_W-1:0] o_wdata, o_rdata;
  logic [MASK_W-1:0] o_wmask;

  function automatic int model_pick(input logic [1:0] pend);
`ifdef YSYX_23060025_ARB_RR_EN
    int last;
    last = (served_q.size() == 0) ? 1 : served_q[$];
    if (pend == 2'b11) return (last == 0) ? 1 : 0;
`endif
    if (pend == 2'b11) return 1;
    return pend[1] ? 1 : 0;
  endfunction

  function automatic logic [4:0] outs();
    return {mem_if.req_valid, m0_if.req_ready, m1_if.req_ready, m0_if.resp_valid, m1_if.resp_valid};
  endfunction

  task automatic set_valid(input int m, input logic v);
    if (m == 0) m0_if.req_valid = v;
    else        m1_if.req_valid = v;
  endtask

  task automatic drive(input int m);
    if (m == 0) begin
      m0_if.req_addr = p_addr[0]; m0_if.req_wen = p_wen[0];
      m0_if.req_wdata = p_wdata[0]; m0_if.req_wmask = p_wmask[0];
    end else begin
      m1_if.req_addr = p_addr[1]; m1_if.req_wen = p_wen[1];
      m1_if.req_wdata = p_wdata[1]; m1_if.req_wmask = p_wmask[1];
    end
    set_valid(m, 1'b1);
  endtask

  task automatic new_req(input int m);
    p_addr[m]  = $urandom;
    p_wen[m]   = 1'($urandom_range(0, 1));
    p_wdata[m] = $urandom;
    p_wmask[m] = MASK_W'($urandom);
    drive(m);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m0_if.req_valid = 0; m1_if.req_valid = 0;
    mem_if.req_ready = 0; mem_if.resp_valid = 0; mem_if.resp_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    served_q.delete();
  endtask

  // Called just after a rising edge in a cycle where the arbiter is idle.
  // Acts as the memory: stalls ready for 'stall' REQ cycles, answers 'dly'
  // cycles into RESP. Optionally drops/raises a master's valid in REQ cycle 1
  // and pulses a stray mem_resp_valid in REQ cycle 0. Returns just after the
  // edge that puts the arbiter back in IDLE.
  task automatic serve_mem(input int stall, input int dly, input logic [DATA_W-1:0] rdata,
                           input int drop_m, input int raise_m, input logic spur);
    logic hs;
    o_gnt = -1; o_rdy_cyc = -1; o_req_cycles = 0; o_early_resp = 0; o_resp_reqv = 0;
    o_rdy[0] = 0; o_rdy[1] = 0; o_resp[0] = 0; o_resp[1] = 0;
    o_first_valid = 0; o_stable = 1; o_timeout = 0; o_rdata = '0;
    mem_if.req_ready = 0; mem_if.resp_valid = 0;
    @(negedge clk);
    o_idle_valid = mem_if.req_valid;
    @(posedge clk); #1;
    hs = 0;
    for (int c = 0; c < 16 && !hs; c++) begin
      mem_if.req_ready  = (c >= stall);
      mem_if.resp_valid = spur && (c == 0);
      mem_if.resp_rdata = $urandom;
      if (c == 1) begin
        if (drop_m >= 0) set_valid(drop_m, 1'b0);
        if (raise_m >= 0) new_req(raise_m);
      end
      @(negedge clk);
      if (mem_if.req_valid) o_req_cycles++;
      if (c == 0) begin
        o_first_valid = mem_if.req_valid;
      end else if (mem_if.req_addr !== o_addr || mem_if.req_wen !== o_wen ||
                   mem_if.req_wdata !== o_wdata || mem_if.req_wmask !== o_wmask) begin
        o_stable = 0;
      end
      o_addr = mem_if.req_addr; o_wen = mem_if.req_wen;
      o_wdata = mem_if.req_wdata; o_wmask = mem_if.req_wmask;
      if (m0_if.resp_valid || m1_if.resp_valid) o_early_resp++;
      if (m0_if.req_ready) begin o_rdy[0]++; o_gnt = 0; o_rdy_cyc = c; end
      if (m1_if.req_ready) begin o_rdy[1]++; o_gnt = 1; o_rdy_cyc = c; end
      hs = mem_if.req_valid && mem_if.req_ready;
      @(posedge clk); #1;
    end
    mem_if.req_ready = 0; mem_if.resp_valid = 0;
    if (!hs) begin
      o_timeout = 1;
      return;
    end
    if (o_gnt >= 0) set_valid(o_gnt, 1'b0);
    for (int d = 0; d <= dly; d++) begin
      mem_if.resp_valid = (d == dly);
      mem_if.resp_rdata = (d == dly) ? rdata : DATA_W'($urandom);
      @(negedge clk);
      if (mem_if.req_valid) o_resp_reqv++;
      if (d < dly) begin
        if (m0_if.resp_valid || m1_if.resp_valid) o_early_resp++;
      end else begin
        o_resp[0] = m0_if.resp_valid;
        o_resp[1] = m1_if.resp_valid;
        o_rdata = (o_gnt == 1) ? m1_if.resp_rdata : m0_if.resp_rdata;
      end
      @(posedge clk); #1;
    end
    mem_if.resp_valid = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m0_if.req_valid = 1; m1_if.req_valid = 1;
    mem_if.req_ready = 1; mem_if.resp_valid = 1; mem_if.resp_rdata = 32'h1234_5678;
    repeat (2) @(negedge clk);
    checks++;
    if (outs() !== 5'b0) begin
      failures++; $display("FAIL reset_outputs actual=%b required=00000", outs());
    end
    checks++;
    if (m1_if.resp_rdata !== 32'h1234_5678) begin
      failures++; $display("FAIL reset_rdata_pass actual=%h required=12345678", m1_if.resp_rdata);
    end
    @(posedge clk); #1;
    m0_if.req_valid = 0; m1_if.req_valid = 0;
    mem_if.req_ready = 0; mem_if.resp_valid = 0;
    rst_n = 1'b1;
    served_q.delete();
    @(negedge clk);
    checks++;
    if (outs() !== 5'b0) begin
      failures++; $display("FAIL post_reset_idle actual=%b required=00000", outs());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ifu_read();
    do_reset();
    p_addr[0] = 32'h8000_0000; p_wen[0] = 0; p_wdata[0] = '0; p_wmask[0] = '0;
    drive(0);
    serve_mem(0, 1, 32'h0000_0413, -1, -1, 1'b0);
    checks++;
    if (o_timeout !== 0 || o_idle_valid !== 0 || o_first_valid !== 1) begin
      failures++; $display("FAIL ifu_latency actual=to%0d idle%0d first%0d required=to0 idle0 first1",
                           o_timeout, o_idle_valid, o_first_valid);
    end
    checks++;
    if (o_gnt !== 0 || o_rdy[0] !== 1 || o_rdy[1] !== 0) begin
      failures++; $display("FAIL ifu_ready actual=gnt%0d r0=%0d r1=%0d required=gnt0 r0=1 r1=0",
                           o_gnt, o_rdy[0], o_rdy[1]);
    end
    checks++;
    if (o_addr !== 32'h8000_0000 || o_wen !== 0) begin
      failures++; $display("FAIL ifu_payload actual=%h/%0d required=80000000/0", o_addr, o_wen);
    end
    checks++;
    if (o_resp[0] !== 1 || o_resp[1] !== 0 || o_early_resp !== 0 || o_rdata !== 32'h0000_0413) begin
      failures++; $display("FAIL ifu_resp actual=v0=%0d v1=%0d early=%0d rdata=%h required=1 0 0 00000413",
                           o_resp[0], o_resp[1], o_early_resp, o_rdata);
    end
    served_q.push_back(0);
  endtask

  task automatic test_arb_order();
    int exp;
    int seq [4];
`ifdef YSYX_23060025_ARB_RR_EN
    seq = '{0, 1, 0, 1};
`else
    seq = '{1, 1, 1, 1};
`endif
    do_reset();
    new_req(0); new_req(1);
    for (int i = 0; i < 4; i++) begin
      exp = model_pick(2'b11);
      serve_mem($urandom_range(0, 2), $urandom_range(0, 2), DATA_W'($urandom), -1, -1, 1'b0);
      checks++;
      if (o_gnt !== exp || o_gnt !== seq[i]) begin
        failures++; $display("FAIL arb_order[%0d] actual=%0d required=%0d", i, o_gnt, seq[i]);
      end
      checks++;
      if (o_addr !== p_addr[seq[i]] || o_wdata !== p_wdata[seq[i]]) begin
        failures++; $display("FAIL arb_payload[%0d] actual=%h required=%h", i, o_addr, p_addr[seq[i]]);
      end
      served_q.push_back(exp);
      if (o_gnt >= 0 && i < 3) new_req(o_gnt);
    end
  endtask

  task automatic test_lsu_write_stall();
    do_reset();
    p_addr[1] = 32'h8000_0100; p_wen[1] = 1; p_wdata[1] = 32'hDEAD_BEEF; p_wmask[1] = 4'hF;
    drive(1);
    serve_mem(3, 0, DATA_W'($urandom), -1, -1, 1'b0);
    checks++;
    if (o_req_cycles !== 4 || o_stable !== 1) begin
      failures++; $display("FAIL lsu_stall_hold actual=cycles%0d stable%0d required=cycles4 stable1",
                           o_req_cycles, o_stable);
    end
    checks++;
    if (o_rdy[1] !== 1 || o_rdy_cyc !== 3 || o_rdy[0] !== 0) begin
      failures++; $display("FAIL lsu_ready_pulse actual=r1=%0d at%0d r0=%0d required=1 at3 0",
                           o_rdy[1], o_rdy_cyc, o_rdy[0]);
    end
    checks++;
    if (o_addr !== 32'h8000_0100 || o_wen !== 1 || o_wdata !== 32'hDEAD_BEEF || o_wmask !== 4'hF) begin
      failures++; $display("FAIL lsu_payload actual=%h %0d %h %h required=80000100 1 deadbeef f",
                           o_addr, o_wen, o_wdata, o_wmask);
    end
    checks++;
    if (o_resp[1] !== 1 || o_resp[0] !== 0) begin
      failures++; $display("FAIL lsu_resp actual=v0=%0d v1=%0d required=v0=0 v1=1", o_resp[0], o_resp[1]);
    end
  endtask

  task automatic test_spurious_resp();
    logic [DATA_W-1:0] rd;
    do_reset();
    mem_if.resp_valid = 1; mem_if.resp_rdata = $urandom;
    @(negedge clk);
    checks++;
    if (outs() !== 5'b0) begin
      failures++; $display("FAIL spur_idle actual=%b required=00000", outs());
    end
    @(posedge clk); #1;
    mem_if.resp_valid = 0;
    @(negedge clk);
    checks++;
    if (outs() !== 5'b0) begin
      failures++; $display("FAIL spur_idle_after actual=%b required=00000", outs());
    end
    @(posedge clk); #1;
    rd = $urandom;
    new_req(0);
    serve_mem(2, 1, rd, -1, -1, 1'b1);
    checks++;
    if (o_early_resp !== 0 || o_req_cycles !== 3 || o_timeout !== 0) begin
      failures++; $display("FAIL spur_req actual=early%0d cycles%0d to%0d required=early0 cycles3 to0",
                           o_early_resp, o_req_cycles, o_timeout);
    end
    checks++;
    if (o_resp[0] !== 1 || o_rdata !== rd) begin
      failures++; $display("FAIL spur_req_resp actual=%0d %h required=1 %h", o_resp[0], o_rdata, rd);
    end
  endtask

  task automatic test_valid_drop();
    do_reset();
    new_req(0);
    serve_mem(3, 1, DATA_W'($urandom), 0, 1, 1'b0);
    checks++;
    if (o_req_cycles !== 4 || o_gnt !== 0 || o_rdy[1] !== 0 || o_stable !== 1 || o_addr !== p_addr[0]) begin
      failures++; $display("FAIL drop_no_switch actual=cycles%0d gnt%0d r1=%0d stable%0d required=4 0 0 1",
                           o_req_cycles, o_gnt, o_rdy[1], o_stable);
    end
    checks++;
    if (o_resp[0] !== 1 || o_resp[1] !== 0 || o_resp_reqv !== 0) begin
      failures++; $display("FAIL drop_resp actual=v0=%0d v1=%0d reqv=%0d required=1 0 0",
                           o_resp[0], o_resp[1], o_resp_reqv);
    end
    served_q.push_back(0);
    serve_mem(0, 0, DATA_W'($urandom), -1, -1, 1'b0);
    checks++;
    if (o_gnt !== 1 || o_addr !== p_addr[1] || o_resp[1] !== 1) begin
      failures++; $display("FAIL drop_next actual=gnt%0d addr%h v1=%0d required=gnt1 addr%h v1=1",
                           o_gnt, o_addr, o_resp[1], p_addr[1]);
    end
  endtask

  task automatic test_reset_mid_resp();
    int exp;
    logic [DATA_W-1:0] rd;
    do_reset();
    new_req(0);
    mem_if.req_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (mem_if.req_valid !== 1) begin
      failures++; $display("FAIL rstmid_req actual=%0d required=1", mem_if.req_valid);
    end
    @(posedge clk); #1;
    set_valid(0, 1'b0);
    mem_if.req_ready = 0; mem_if.resp_valid = 1; mem_if.resp_rdata = $urandom;
    @(negedge clk);
    checks++;
    if (m0_if.resp_valid !== 1) begin
      failures++; $display("FAIL rstmid_resp actual=%0d required=1", m0_if.resp_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 5'b0) begin
      failures++; $display("FAIL rstmid_async actual=%b required=00000", outs());
    end
    mem_if.resp_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    served_q.delete();
    new_req(0); new_req(1);
    exp = model_pick(2'b11);
    rd = $urandom;
    serve_mem(0, 0, rd, -1, -1, 1'b0);
    checks++;
    if (o_timeout !== 0 || o_first_valid !== 1 || o_gnt !== exp || o_resp[exp] !== 1 || o_rdata !== rd) begin
      failures++; $display("FAIL rstmid_next actual=to%0d first%0d gnt%0d rdata%h required=to0 first1 gnt%0d rdata%h",
                           o_timeout, o_first_valid, o_gnt, o_rdata, exp, rd);
    end
  endtask

  task automatic test_random();
    int exp;
    int bad;
    logic [1:0] pend;
    logic [DATA_W-1:0] rd;
    do_reset();
    bad = 0;
    for (int r = 0; r < 60; r++) begin
      if (!m0_if.req_valid && $urandom_range(0, 1) == 1) new_req(0);
      if (!m1_if.req_valid && $urandom_range(0, 1) == 1) new_req(1);
      if (!m0_if.req_valid && !m1_if.req_valid) new_req(int'($urandom_range(0, 1)));
      pend = {m1_if.req_valid, m0_if.req_valid};
      exp = model_pick(pend);
      rd = $urandom;
      serve_mem($urandom_range(0, 3), $urandom_range(0, 3), rd, -1, -1, 1'($urandom_range(0, 1)));
      checks++;
      if (o_timeout !== 0 || o_gnt !== exp || o_rdy[exp] !== 1 || o_rdy[1-exp] !== 0 ||
          o_addr !== p_addr[exp] || o_wen !== p_wen[exp] || o_wdata !== p_wdata[exp] ||
          o_wmask !== p_wmask[exp] || o_stable !== 1 || o_early_resp !== 0 ||
          o_resp[exp] !== 1 || o_resp[1-exp] !== 0 || o_rdata !== rd || o_resp_reqv !== 0) begin
        failures++; bad++;
        if (bad < 5)
          $display("FAIL random[%0d] actual=gnt%0d addr%h resp%0d%0d rdata%h to%0d required=gnt%0d addr%h rdata%h",
                   r, o_gnt, o_addr, o_resp[1], o_resp[0], o_rdata, o_timeout, exp, p_addr[exp], rd);
      end
      served_q.push_back(exp);
    end
  endtask

  initial begin
    m0_if.req_valid = 0; m0_if.req_addr = '0; m0_if.req_wen = 0; m0_if.req_wdata = '0; m0_if.req_wmask = '0;
    m1_if.req_valid = 0; m1_if.req_addr = '0; m1_if.req_wen = 0; m1_if.req_wdata = '0; m1_if.req_wmask = '0;
    mem_if.req_ready = 0; mem_if.resp_valid = 0; mem_if.resp_rdata = '0;
    test_reset();
    test_ifu_read();
    test_arb_order();
    test_lsu_write_stall();
    test_spurious_resp();
    test_valid_drop();
    test_reset_mid_resp();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
